// File: rtl/jtdd_vtimer.sv
// Video timing generator: H/V counters, blanking/sync windows,
// flip-aware positions, delayed blanking, raster interrupt, frame toggle.
module jtdd_vtimer #(
    parameter int HCNT_W    = 9,
    parameter int VCNT_W    = 9,
    parameter int HTOTAL    = 384,
    parameter int VTOTAL    = 264,
    parameter int HB_START  = 256,
    parameter int HB_END    = 0,
    parameter int HS_START  = 288,
    parameter int HS_END    = 320,
    parameter int VB_START  = 240,
    parameter int VB_END    = 16,
    parameter int VS_START  = 248,
    parameter int VS_END    = 251,
    parameter int BLANK_DLY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pxl_cen,
    input  logic              flip,
    input  logic [VCNT_W-1:0] irq_line,
    input  logic              irq_en,
    input  logic              irq_ack,
    output logic [HCNT_W-1:0] H,
    output logic [VCNT_W-1:0] V,
    output logic [7:0]        HPOS,
    output logic [7:0]        VPOS,
    output logic              HBL,
    output logic              VBL,
    output logic              HS,
    output logic              VS,
    output logic              LHBL_dly,
    output logic              LVBL_dly,
    output logic              irq,
    output logic              vbl_pulse,
    output logic              frame
);

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(HTOTAL - 1);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(VTOTAL - 1);
    localparam logic [HCNT_W-1:0] HB_S   = HCNT_W'(HB_START);
    localparam logic [HCNT_W-1:0] HB_E   = HCNT_W'(HB_END);
    localparam logic [HCNT_W-1:0] HS_S   = HCNT_W'(HS_START);
    localparam logic [HCNT_W-1:0] HS_E   = HCNT_W'(HS_END);
    localparam logic [VCNT_W-1:0] VB_S   = VCNT_W'(VB_START);
    localparam logic [VCNT_W-1:0] VB_E   = VCNT_W'(VB_END);
    localparam logic [VCNT_W-1:0] VS_S   = VCNT_W'(VS_START);
    localparam logic [VCNT_W-1:0] VS_E   = VCNT_W'(VS_END);

    logic              hwrap;
    logic              vwrap;
    logic [HCNT_W-1:0] h_nxt;
    logic [VCNT_W-1:0] v_nxt;
    logic              hbl_nxt;
    logic              hs_nxt;
    logic              vbl_nxt;
    logic              vs_nxt;
    logic              irq_set;

    // Clear has priority so START==END never asserts.
    function automatic logic win(input logic cur, input logic set,
                                 input logic clr);
        return clr ? 1'b0 : (set ? 1'b1 : cur);
    endfunction

    always_comb begin
        hwrap   = (H == H_LAST);
        vwrap   = hwrap && (V == V_LAST);
        h_nxt   = hwrap ? '0 : H + 1'b1;
        v_nxt   = V;
        if (hwrap)
            v_nxt = (V == V_LAST) ? '0 : V + 1'b1;
        hbl_nxt = win(HBL, h_nxt == HB_S, h_nxt == HB_E);
        hs_nxt  = win(HS, h_nxt == HS_S, h_nxt == HS_E);
        vbl_nxt = VBL;
        vs_nxt  = VS;
        if (hwrap) begin
            vbl_nxt = win(VBL, v_nxt == VB_S, v_nxt == VB_E);
            vs_nxt  = win(VS, v_nxt == VS_S, v_nxt == VS_E);
        end
        irq_set = pxl_cen && hwrap && irq_en && (v_nxt == irq_line);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            H         <= '0;
            V         <= '0;
            HPOS      <= '0;
            VPOS      <= '0;
            HBL       <= 1'b1;
            VBL       <= 1'b1;
            HS        <= 1'b0;
            VS        <= 1'b0;
            vbl_pulse <= 1'b0;
            frame     <= 1'b0;
        end else begin
            vbl_pulse <= 1'b0;
            if (pxl_cen) begin
                H         <= h_nxt;
                V         <= v_nxt;
                HPOS      <= 8'(h_nxt) ^ {8{flip}};
                VPOS      <= 8'(v_nxt) ^ {8{flip}};
                HBL       <= hbl_nxt;
                VBL       <= vbl_nxt;
                HS        <= hs_nxt;
                VS        <= vs_nxt;
                vbl_pulse <= vbl_nxt & ~VBL;
                if (vwrap)
                    frame <= ~frame;
            end
        end
    end

    // A same-cycle set beats the acknowledge; disabling always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else if (!irq_en)
            irq <= 1'b0;
        else if (irq_set)
            irq <= 1'b1;
        else if (irq_ack)
            irq <= 1'b0;
    end

    generate
        if (BLANK_DLY == 0) begin : g_nodly
            assign LHBL_dly = ~HBL;
            assign LVBL_dly = ~VBL;
        end else begin : g_dly
            logic [BLANK_DLY-1:0] hsr;
            logic [BLANK_DLY-1:0] vsr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hsr <= '0;
                    vsr <= '0;
                end else if (pxl_cen) begin
                    hsr <= BLANK_DLY'({hsr, ~HBL});
                    vsr <= BLANK_DLY'({vsr, ~VBL});
                end
            end

            assign LHBL_dly = hsr[BLANK_DLY-1];
            assign LVBL_dly = vsr[BLANK_DLY-1];
        end
    endgenerate

endmodule

// File: tb/tb_jtdd_vtimer.sv
// Scoreboard bench for jtdd_vtimer: directed stimulus queues expected
// values, a negedge monitor pops and compares them.
module tb_jtdd_vtimer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pxl_cen;
    logic       flip;
    logic       irq_en;
    logic       irq_ack;
    logic [8:0] irq_line;
    logic [3:0] s_irq_line;

    always #5 clk = ~clk;

    logic [8:0] h, v;
    logic [7:0] hpos, vpos;
    logic       hbl, vbl, hs, vs, lh, lv, irq, vblp, frame;

    logic [8:0] d_h, d_v;
    logic [7:0] d_hpos, d_vpos;
    logic       d_hbl, d_vbl, d_hs, d_vs, d_lh, d_lv;
    logic       d_irq, d_vblp, d_frame;

    logic [4:0] s_h;
    logic [3:0] s_v;
    logic [7:0] s_hpos, s_vpos;
    logic       s_hbl, s_vbl, s_hs, s_vs, s_lh, s_lv;
    logic       s_irq, s_vblp, s_frame;

    jtdd_vtimer dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
        .irq_line(irq_line), .irq_en(irq_en), .irq_ack(irq_ack),
        .H(h), .V(v), .HPOS(hpos), .VPOS(vpos),
        .HBL(hbl), .VBL(vbl), .HS(hs), .VS(vs),
        .LHBL_dly(lh), .LVBL_dly(lv), .irq(irq),
        .vbl_pulse(vblp), .frame(frame)
    );

    jtdd_vtimer #(
        .HS_START(300), .HS_END(300), .BLANK_DLY(0)
    ) dut_d (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
        .irq_line(irq_line), .irq_en(irq_en), .irq_ack(irq_ack),
        .H(d_h), .V(d_v), .HPOS(d_hpos), .VPOS(d_vpos),
        .HBL(d_hbl), .VBL(d_vbl), .HS(d_hs), .VS(d_vs),
        .LHBL_dly(d_lh), .LVBL_dly(d_lv), .irq(d_irq),
        .vbl_pulse(d_vblp), .frame(d_frame)
    );

    jtdd_vtimer #(
        .HCNT_W(5), .VCNT_W(4), .HTOTAL(20), .VTOTAL(10),
        .HB_START(14), .HB_END(2), .HS_START(16), .HS_END(16),
        .VB_START(8), .VB_END(1), .VS_START(8), .VS_END(9),
        .BLANK_DLY(0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip),
        .irq_line(s_irq_line), .irq_en(1'b1), .irq_ack(irq_ack),
        .H(s_h), .V(s_v), .HPOS(s_hpos), .VPOS(s_vpos),
        .HBL(s_hbl), .VBL(s_vbl), .HS(s_hs), .VS(s_vs),
        .LHBL_dly(s_lh), .LVBL_dly(s_lv), .irq(s_irq),
        .vbl_pulse(s_vblp), .frame(s_frame)
    );

    localparam int S_H = 0, S_V = 1, S_HPOS = 2, S_VPOS = 3;
    localparam int S_HBL = 4, S_VBL = 5, S_HS = 6, S_VS = 7;
    localparam int S_LH = 8, S_LV = 9, S_IRQ = 10, S_FRAME = 11;
    localparam int S_VBLP = 12, D_LH = 13, D_HS = 14, D_HSCNT = 15;
    localparam int M_FRAME = 16, M_PULSES = 17, M_RISES = 18;
    localparam int M_IRQCNT = 19;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    int   s_pulses = 0;
    int   s_rises  = 0;
    int   s_irq_hi = 0;
    int   d_hs_hi  = 0;
    logic s_hbl_q  = 1'b1;

    int hm, vm, tk;

    // Event counters sample pre-edge values at each clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            s_hbl_q <= 1'b1;
        end else begin
            s_hbl_q <= s_hbl;
            if (s_vblp) s_pulses <= s_pulses + 1;
            if (s_hbl && !s_hbl_q) s_rises <= s_rises + 1;
            if (s_irq) s_irq_hi <= s_irq_hi + 1;
            if (d_hs) d_hs_hi <= d_hs_hi + 1;
        end
    end

    function automatic int sample(input int sel);
        case (sel)
            S_H:      return int'(h);
            S_V:      return int'(v);
            S_HPOS:   return int'(hpos);
            S_VPOS:   return int'(vpos);
            S_HBL:    return int'(hbl);
            S_VBL:    return int'(vbl);
            S_HS:     return int'(hs);
            S_VS:     return int'(vs);
            S_LH:     return int'(lh);
            S_LV:     return int'(lv);
            S_IRQ:    return int'(irq);
            S_FRAME:  return int'(frame);
            S_VBLP:   return int'(vblp);
            D_LH:     return int'(d_lh);
            D_HS:     return int'(d_hs);
            D_HSCNT:  return d_hs_hi;
            M_FRAME:  return int'(s_frame);
            M_PULSES: return s_pulses;
            M_RISES:  return s_rises;
            M_IRQCNT: return s_irq_hi;
            default:  return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            int   a;
            e = q.pop_front();
            a = sample(e.sel);
            n_chk = n_chk + 1;
            if (a != e.exp) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %0d expected %0d", e.name, a, e.exp);
            end
        end
    end

    task automatic chk(input string nm, input int sel, input int val);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = val;
        q.push_back(e);
    endtask

    task automatic cyc(input logic cen);
        pxl_cen = cen;
        @(posedge clk);
        #1;
        if (cen) begin
            tk = tk + 1;
            if (hm == 383) begin
                hm = 0;
                vm = (vm == 263) ? 0 : vm + 1;
            end else begin
                hm = hm + 1;
            end
        end
    endtask

    task automatic tick(input bit slow);
        if (slow) cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic run_to(input int th, input int tv, input bit slow);
        int n;
        n = 0;
        while (!(hm == th && vm == tv)) begin
            tick(slow);
            n = n + 1;
            if (n > 110000) begin
                n_fail = n_fail + 1;
                $display("FAIL run_to: got no position %0d/%0d", th, tv);
                break;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_h"}, S_H, 0);
        chk({tag, "_v"}, S_V, 0);
        chk({tag, "_hpos"}, S_HPOS, 0);
        chk({tag, "_vpos"}, S_VPOS, 0);
        chk({tag, "_hbl"}, S_HBL, 1);
        chk({tag, "_vbl"}, S_VBL, 1);
        chk({tag, "_hs"}, S_HS, 0);
        chk({tag, "_vs"}, S_VS, 0);
        chk({tag, "_lh"}, S_LH, 0);
        chk({tag, "_lv"}, S_LV, 0);
        chk({tag, "_irq"}, S_IRQ, 0);
        chk({tag, "_frame"}, S_FRAME, 0);
        chk({tag, "_vblp"}, S_VBLP, 0);
        chk({tag, "_dlh"}, D_LH, 0);
    endtask

    initial begin
        int ep, er, ef;
        rst_n      = 1'b0;
        pxl_cen    = 1'b0;
        flip       = 1'b1;
        irq_en     = 1'b0;
        irq_ack    = 1'b0;
        irq_line   = 9'd100;
        s_irq_line = 4'd10;
        hm = 0; vm = 0; tk = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc(1'b0);
        cyc(1'b0);
        chk("hold_h", S_H, 0);
        chk("hold_hpos", S_HPOS, 0);

        cyc(1'b1);
        chk("first_h", S_H, 1);
        chk("flip_hpos1", S_HPOS, 8'hFE);
        chk("flip_vpos0", S_VPOS, 8'hFF);
        chk("first_hbl", S_HBL, 1);
        chk("first_vbl", S_VBL, 1);
        chk("first_lh", S_LH, 0);

        run_to(255, 0, 1'b0);
        chk("h255", S_H, 255);
        chk("flip_hpos255", S_HPOS, 8'h00);
        flip = 1'b0;
        tick(1'b0);
        chk("hpos256", S_HPOS, 0);
        chk("hbl256_l0", S_HBL, 1);
        tick(1'b0);
        chk("hpos257", S_HPOS, 1);

        run_to(383, 0, 1'b1);
        tick(1'b1);
        chk("wrap_h", S_H, 0);
        chk("wrap_v", S_V, 1);
        chk("wrap_vpos", S_VPOS, 1);
        chk("hbl_clr", S_HBL, 0);
        chk("lh_d0", S_LH, 0);
        chk("dlh_h0", D_LH, 1);
        cyc(1'b0);
        chk("lh_hold", S_LH, 0);
        chk("hbl_hold", S_HBL, 0);
        tick(1'b1);
        chk("lh_d1", S_LH, 0);
        tick(1'b1);
        chk("lh_d2", S_LH, 1);

        run_to(255, 1, 1'b1);
        chk("hbl255", S_HBL, 0);
        tick(1'b1);
        chk("hbl_set", S_HBL, 1);
        chk("lh_r0", S_LH, 1);
        chk("dlh_h256", D_LH, 0);
        tick(1'b1);
        chk("lh_r1", S_LH, 1);
        tick(1'b1);
        chk("lh_r2", S_LH, 0);

        run_to(287, 1, 1'b1);
        chk("hs287", S_HS, 0);
        tick(1'b1);
        chk("hs288", S_HS, 1);
        run_to(300, 1, 1'b1);
        chk("dhs300", D_HS, 0);
        run_to(319, 1, 1'b1);
        chk("hs319", S_HS, 1);
        tick(1'b1);
        chk("hs320", S_HS, 0);

        irq_en = 1'b1;
        run_to(383, 15, 1'b0);
        chk("vbl_l15", S_VBL, 1);
        chk("irq_idle", S_IRQ, 0);
        tick(1'b0);
        chk("vbl_l16", S_VBL, 0);
        chk("v16", S_V, 16);

        run_to(383, 99, 1'b0);
        chk("irq_l99", S_IRQ, 0);
        tick(1'b0);
        chk("irq_v", S_V, 100);
        chk("irq_set", S_IRQ, 1);
        irq_ack = 1'b1;
        cyc(1'b0);
        irq_ack = 1'b0;
        chk("irq_ack", S_IRQ, 0);

        run_to(200, 100, 1'b0);
        chk("pos_h200", S_H, 200);
        chk("pos_v100", S_V, 100);
        irq_line = 9'd101;
        run_to(383, 100, 1'b0);
        irq_ack = 1'b1;
        tick(1'b0);
        irq_ack = 1'b0;
        chk("irq_set_ack", S_IRQ, 1);
        irq_en = 1'b0;
        cyc(1'b0);
        chk("irq_dis", S_IRQ, 0);

        irq_line = 9'd102;
        run_to(383, 101, 1'b0);
        tick(1'b0);
        chk("irq_blk", S_IRQ, 0);

        irq_en   = 1'b1;
        irq_line = 9'd103;
        run_to(383, 102, 1'b0);
        tick(1'b0);
        chk("irq_pend", S_IRQ, 1);

        run_to(200, 103, 1'b0);
        cyc(1'b0);
        ep = (tk >= 160) ? (tk - 160) / 200 + 1 : 0;
        er = (tk >= 14) ? (tk - 14) / 20 + 1 : 0;
        ef = (tk / 200) % 2;
        chk("s_pulses", M_PULSES, ep);
        chk("s_hbl_rises", M_RISES, er);
        chk("s_frame", M_FRAME, ef);
        chk("s_irq_oor", M_IRQCNT, 0);
        chk("d_hs_never", D_HSCNT, 0);
        @(negedge clk);
        #1;

        pxl_cen = 1'b0;
        rst_n   = 1'b0;
        chk_reset("mrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hm = 0; vm = 0; tk = 0;
        tick(1'b0);
        chk("restart_h", S_H, 1);
        chk("restart_v", S_V, 0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
